// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM arbiter slice.
package rom_arb_pkg;

  localparam int unsigned NUM_REQ_MIN = 2;
  localparam int unsigned NUM_REQ_MAX = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
// With mask_en set only the owner (one-hot) may win.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_mask_en,
  input  logic [N-1:0]   i_owner_oh,
  output logic [N-1:0]   o_grant
);

  logic [N-1:0] w_req;
  logic         w_found;

  assign w_req = i_mask_en ? (i_req & i_owner_oh) : i_req;

  // Scan two laps starting at ptr so the search wraps without modular indexing.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!w_found && (k >= int'(i_ptr)) && w_req[k % N]) begin
        o_grant[k % N] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one single-port sync ROM among NUM_REQ requesters,
// with owner-locked bursts and a tag pipeline steering read data back.
// Optional macro ROM_ARB_RSP_REG_EN adds a registered response stage (latency 2).
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [ADDR_WIDTH-1:0]           o_rom_addr,
  input  logic [DATA_WIDTH-1:0]           i_rom_data,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]           o_rsp_data
);

  localparam int unsigned     IDW     = id_width(NUM_REQ);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NUM_REQ - 1);

  if ((NUM_REQ < NUM_REQ_MIN) || (NUM_REQ > NUM_REQ_MAX)) begin : g_bad_num_req
    $error("rom_arbiter: NUM_REQ out of range");
  end

  arb_state_e              r_state;
  logic [IDW-1:0]          r_rr_ptr;
  logic [IDW-1:0]          r_owner;
  logic                    r_tag_valid;
  logic [IDW-1:0]          r_tag_id;
  logic [ADDR_WIDTH-1:0]   r_addr_hold;

  logic [NUM_REQ-1:0]      w_grant;
  logic [NUM_REQ-1:0]      w_ready;
  logic [NUM_REQ-1:0]      w_owner_oh;
  logic                    w_accept;
  logic                    w_gnt_lock;
  logic [IDW-1:0]          w_gnt_id;
  logic [IDW-1:0]          w_next_ptr;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;

  assign w_owner_oh = NUM_REQ'(1) << r_owner;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .i_req      (i_req_valid),
    .i_ptr      (r_rr_ptr),
    .i_mask_en  (r_state == LOCKED),
    .i_owner_oh (w_owner_oh),
    .o_grant    (w_grant)
  );

  // Encode the one-hot grant into an index and pick that requester's address.
  always_comb begin
    w_gnt_id   = '0;
    w_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_id   = IDW'(i);
        w_sel_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign w_ready     = rst ? '0 : w_grant;
  assign w_accept    = |w_ready;
  assign w_gnt_lock  = |(w_ready & i_req_lock);
  assign w_next_ptr  = (w_gnt_id == LAST_ID) ? '0 : (w_gnt_id + IDW'(1));
  assign o_req_ready = w_ready;
  assign o_rom_addr  = w_accept ? w_sel_addr : r_addr_hold;

  // Arbitration FSM, round-robin pointer, address hold and read tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_tag_valid <= 1'b0;
      r_tag_id    <= '0;
      r_addr_hold <= '0;
    end else begin
      r_tag_valid <= w_accept;
      if (w_accept) begin
        r_tag_id    <= w_gnt_id;
        r_rr_ptr    <= w_next_ptr;
        r_addr_hold <= w_sel_addr;
        if (w_gnt_lock) begin
          r_state <= LOCKED;
          r_owner <= w_gnt_id;
        end else begin
          r_state <= ARB;
        end
      end
    end
  end

`ifdef ROM_ARB_RSP_REG_EN
  logic                  r_rsp_valid;
  logic [IDW-1:0]        r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  // Extra response stage: retime ROM data and tag by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_tag_valid;
      r_rsp_id    <= r_tag_id;
      r_rsp_data  <= i_rom_data;
    end
  end

  assign o_rsp_valid = r_rsp_valid ? (NUM_REQ'(1) << r_rsp_id) : '0;
  assign o_rsp_data  = r_rsp_data;
`else
  assign o_rsp_valid = r_tag_valid ? (NUM_REQ'(1) << r_tag_id) : '0;
  assign o_rsp_data  = r_tag_valid ? i_rom_data : '0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios then random traffic,
// compared against a behavioural arbitration/response model.
module tb_rom_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
`ifdef ROM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  // Reference state
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  logic [AW-1:0] m_last_addr;
  bit            pv   [0:1];
  int            pid  [0:1];
  logic [DW-1:0] pdat [0:1];

  always #5 clk = ~clk;

  // Single-port synchronous ROM, one-cycle read latency.
  always @(posedge clk) rom_data <= mem[rom_addr];

  rom_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_lock  (req_lock),
    .i_req_addr  (req_addr),
    .o_req_ready (req_ready),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr       = 0;
    m_locked    = 1'b0;
    m_owner     = 0;
    m_last_addr = '0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pid[i] = 0; pdat[i] = '0;
    end
  endtask

  // Who should win this cycle, or -1.
  function automatic int model_grant();
    if (rst) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input bit l, input int a);
    req_valid[i]         = v;
    req_lock[i]          = l;
    req_addr[i*AW +: AW] = AW'(a);
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int g;
    logic [AW-1:0] a;
    #1;
    if (rst) model_reset();
    g = model_grant();
    a = (g >= 0) ? req_addr[g*AW +: AW] : m_last_addr;
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'(1) << g) : 32'(0));
    chk("rom_addr", 32'(rom_addr), 32'(a));
    if (pv[LAT-1]) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << pid[LAT-1]);
      chk("rsp_data", 32'(rsp_data), 32'(pdat[LAT-1]));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'(0));
    end
    if (rst) chk("rsp_data_rst", 32'(rsp_data), 32'(0));
    @(posedge clk);
    if (!rst) begin
      pv[1] = pv[0]; pid[1] = pid[0]; pdat[1] = pdat[0];
      pv[0] = (g >= 0);
      if (g >= 0) begin
        pid[0]      = g;
        pdat[0]     = mem[a];
        m_ptr       = (g + 1) % N;
        m_locked    = req_lock[g];
        m_owner     = g;
        m_last_addr = a;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[5]    = 8'hA5;
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    // Single requester reading address 5
    set_req(0, 1, 0, 5);
    step();
    set_req(0, 0, 0, 5);
    repeat (3) step();

    // Contention: both valid continuously, grants alternate
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 0, $urandom_range(0, 63));
      set_req(1, 1, 0, $urandom_range(0, 63));
      step();
    end
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    repeat (2) step();

    // Lock burst by req1 at 1,2,3 while req0 waits
    set_req(0, 1, 0, 9); step();
    set_req(1, 1, 1, 1); step();
    set_req(1, 1, 1, 2); step();
    set_req(1, 1, 0, 3); step();
    set_req(1, 0, 0, 0); step();
    set_req(0, 0, 0, 0);
    repeat (2) step();

    // Owner stalls for two cycles mid-burst
    set_req(0, 1, 0, 12); step();
    set_req(1, 1, 1, 20); step();
    set_req(1, 0, 1, 21); step(); step();
    set_req(1, 1, 0, 22); step();
    set_req(1, 0, 0, 0);  step();
    set_req(0, 0, 0, 0);
    repeat (2) step();

    // Reset the cycle after an accept
    set_req(0, 1, 0, 30); step();
    set_req(1, 1, 0, 31);
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    repeat (3) step();

    // Back-to-back reads at 0..3
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, i);
      step();
    end
    set_req(0, 0, 0, 0);
    repeat (3) step();

    // Random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 30),
                $urandom_range(0, 63));
      rst = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
